// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
// Optional hold watchdog is enabled with RR_ARB_HOLD_TIMEOUT_EN.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester/downstream bundle of the burst arbiter; timeout_o exists only
// when RR_ARB_HOLD_TIMEOUT_EN is defined.
interface rr_burst_arbiter_if #(
  parameter int N        = 4,
  parameter int IDX_BITS = $clog2(N)
);
  logic [N-1:0]        req_i;
  logic [N-1:0]        req_last_i;
  logic [N-1:0]        gnt_o;
  logic [IDX_BITS-1:0] gnt_idx_o;
  logic                busy_o;
  logic                out_valid_o;
  logic                out_ready_i;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
  logic                timeout_o;

  modport slave (
    input  req_i, req_last_i, out_ready_i,
    output gnt_o, gnt_idx_o, busy_o, out_valid_o, timeout_o
  );
  modport master (
    output req_i, req_last_i, out_ready_i,
    input  gnt_o, gnt_idx_o, busy_o, out_valid_o, timeout_o
  );
`else
  modport slave (
    input  req_i, req_last_i, out_ready_i,
    output gnt_o, gnt_idx_o, busy_o, out_valid_o
  );
  modport master (
    output req_i, req_last_i, out_ready_i,
    input  gnt_o, gnt_idx_o, busy_o, out_valid_o
  );
`endif
endinterface

// File: rtl/rr_burst_arbiter_find_first_one.sv
// Rotating first-one search: lowest set bit of data_i at or after start_i,
// wrapping modulo WIDTH (WIDTH must be a power of two).
module find_first_one #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [IW-1:0]    start_i,
  output logic [IW-1:0]    index_o,
  output logic             valid_one_o
);

  logic [IW-1:0] idx;

  // Scan from the far end back toward start_i so the nearest hit wins last.
  always_comb begin
    index_o     = '0;
    valid_one_o = 1'b0;
    idx         = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx = start_i + IW'(i);
      if (data_i[idx]) begin
        index_o     = idx;
        valid_one_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with per-burst lock onto one valid/ready channel.
// Define RR_ARB_HOLD_TIMEOUT_EN to add the MAX_HOLD stall watchdog and timeout_o.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_BITS = $clog2(N),
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  rr_burst_arbiter_if.slave  bus
);

  if (N < 2 || (N & (N - 1)) != 0 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_burst_arbiter: N must be a power of two >= 2 and MAX_HOLD >= 1");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [IDX_BITS-1:0] owner_q, owner_d;
  logic [IDX_BITS-1:0] ffo_idx;
  logic                ffo_valid;
  logic [N-1:0]        gnt;
  logic                out_valid;
  logic                beat;

  find_first_one #(.WIDTH(N), .IW(IDX_BITS)) u_ffo (
    .data_i      (bus.req_i),
    .start_i     (ptr_q),
    .index_o     (ffo_idx),
    .valid_one_o (ffo_valid)
  );

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt       = '0;
    out_valid = 1'b0;
    beat      = 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (ffo_valid) begin
          owner_d = ffo_idx;
          state_d = ARB_BUSY;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ARB_BUSY: begin
        gnt[owner_q] = 1'b1;
        out_valid    = bus.req_i[owner_q];
        beat         = out_valid & bus.out_ready_i;
        // Finishing a burst makes the served requester lowest priority.
        if (beat && bus.req_last_i[owner_q]) begin
          state_d = ARB_IDLE;
          ptr_d   = owner_q + IDX_BITS'(1);
        end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        if (beat) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          hold_cnt_d = CNT_W'(MAX_HOLD);
          state_d    = ARB_IDLE;
          ptr_d      = owner_q + IDX_BITS'(1);
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`endif

  assign bus.gnt_o       = gnt;
  assign bus.gnt_idx_o   = owner_q;
  assign bus.busy_o      = (state_q == ARB_BUSY);
  assign bus.out_valid_o = out_valid;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter (N=4); the watchdog
// scenario is compiled in only with RR_ARB_HOLD_TIMEOUT_EN.
module tb_rr_burst_arbiter;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rr_burst_arbiter_if #(.N(4)) bus ();

  rr_burst_arbiter #(.N(4), .MAX_HOLD(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = '0;
    bus.req_last_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 4'b1010;
    bus.req_last_i = '0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({bus.gnt_o, bus.gnt_idx_o, bus.busy_o, bus.out_valid_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b idx=%0d busy=%b vld=%b want all 0",
               bus.gnt_o, bus.gnt_idx_o, bus.busy_o, bus.out_valid_o);
    end
    #4;
    rst_n = 1'b1;
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0010 || bus.gnt_idx_o !== 2'd1 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got gnt=%b idx=%0d busy=%b want 0010 1 1",
               bus.gnt_o, bus.gnt_idx_o, bus.busy_o);
    end
    tick();
    tick();
    bus.req_last_i = 4'b0010;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL third_beat got vld=%b gnt=%b want 1 0010", bus.out_valid_o, bus.gnt_o);
    end
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap got gnt=%b busy=%b want 0000 0", bus.gnt_o, bus.busy_o);
    end
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b1000 || bus.gnt_idx_o !== 2'd3) begin
      errors++;
      $display("FAIL ptr_after_1 got gnt=%b idx=%0d want 1000 3", bus.gnt_o, bus.gnt_idx_o);
    end
    bus.req_i = 4'b1111;
    bus.req_last_i = 4'b1000;
    tick(); tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0001 || bus.gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL wrap_ptr got gnt=%b idx=%0d want 0001 0", bus.gnt_o, bus.gnt_idx_o);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req_i = 4'b1111;
    bus.req_last_i = 4'b1111;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL fair_idle[%0d] got gnt=%b busy=%b want 0000 0", k, bus.gnt_o, bus.busy_o);
      end
      tick(); #1;
      checks++;
      if (bus.gnt_o !== exp_gnt[k] || bus.out_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL fair_grant[%0d] got gnt=%b vld=%b want %b 1",
                 k, bus.gnt_o, bus.out_valid_o, exp_gnt[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_i = 4'b1100;
    bus.req_last_i = 4'b0100;
    bus.out_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.gnt_o !== 4'b0100 || bus.out_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d] got gnt=%b vld=%b busy=%b want 0100 1 1",
                 k, bus.gnt_o, bus.out_valid_o, bus.busy_o);
      end
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got gnt=%b busy=%b want 0000 0", bus.gnt_o, bus.busy_o);
    end
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b1000) begin
      errors++;
      $display("FAIL stall_next got gnt=%b want 1000", bus.gnt_o);
    end
  endtask

  task automatic test_req_gap();
    do_reset();
    bus.req_i = 4'b0010;
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    bus.req_i = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b0 || bus.gnt_o !== 4'b0010 || bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL gap[%0d] got vld=%b gnt=%b busy=%b want 0 0010 1",
                 k, bus.out_valid_o, bus.gnt_o, bus.busy_o);
      end
      tick();
    end
    bus.req_i = 4'b1010;
    bus.req_last_i = 4'b0010;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL gap_resume got vld=%b gnt=%b want 1 0010", bus.out_valid_o, bus.gnt_o);
    end
    tick(); tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b1000 || bus.gnt_idx_o !== 2'd3) begin
      errors++;
      $display("FAIL gap_next got gnt=%b idx=%0d want 1000 3", bus.gnt_o, bus.gnt_idx_o);
    end
  endtask

  task automatic test_async_reset();
    // Arbiter is now BUSY with owner 3 from the previous scenario.
    bus.req_last_i = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.gnt_idx_o, bus.busy_o, bus.out_valid_o} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got gnt=%b idx=%0d busy=%b vld=%b want all 0",
               bus.gnt_o, bus.gnt_idx_o, bus.busy_o, bus.out_valid_o);
    end
    tick();
    rst_n = 1'b1;
    bus.req_i = 4'b1111;
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0001 || bus.gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL async_ptr got gnt=%b idx=%0d want 0001 0", bus.gnt_o, bus.gnt_idx_o);
    end
  endtask

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.req_i = 4'b0011;
    bus.out_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0 || bus.gnt_o !== 4'b0001) begin
        errors++;
        $display("FAIL hold[%0d] got busy=%b to=%b gnt=%b want 1 0 0001",
                 k, bus.busy_o, bus.timeout_o, bus.gnt_o);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse got busy=%b to=%b want 0 1", bus.busy_o, bus.timeout_o);
    end
    tick(); #1;
    checks++;
    if (bus.gnt_o !== 4'b0010 || bus.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next got gnt=%b to=%b want 0010 0", bus.gnt_o, bus.timeout_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_req_gap();
    test_async_reset();
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout reached got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter sharing one downstream valid/ready channel among N requesters, with per-burst lock.
- Arbitration search is a rotating first-one lookup over the request vector, starting at a registered priority pointer.
- Sits between master-side request queues and a single shared port, e.g. the I/D fetch merge in front of the bus interface.

Parameters:
- N, 4, number of requesters; power of 2, >= 2 (elaboration-time check).
- IDX_BITS, $clog2(N), width of requester index.
- MAX_HOLD, 16, cycle budget for the hold watchdog (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  N  per-requester request; must stay high for the whole burst
- req_last_i  in  N  per-requester last-beat flag, sampled only for the owner
- gnt_o  out  N  one-hot grant to the current owner, 0 in IDLE
- gnt_idx_o  out  IDX_BITS  owner index, valid while busy_o
- busy_o  out  1  lock held (state BUSY)
- out_valid_o  out  1  downstream valid = req_i[owner] while BUSY
- out_ready_i  in  1  downstream ready

Behaviour:
- Reset (async, rst_ni low): state=IDLE, ptr=0, owner=0; gnt_o=0, gnt_idx_o=0, busy_o=0, out_valid_o=0.
- State IDLE:
  - Outputs gnt_o=0, out_valid_o=0.
  - If |req_i, first-one search over req_i starting at ptr, wrapping modulo N.
  - Next edge: owner <= found index; state <= BUSY.
  - If req_i==0, stay in IDLE.
- State BUSY:
  - gnt_o = 1<<owner, busy_o=1, out_valid_o = req_i[owner].
  - Beat = out_valid_o & out_ready_i.
  - Beat with req_last_i[owner]=1: state <= IDLE, ptr <= owner+1 (natural wrap, N power of 2).
  - Other requests are ignored while BUSY.
  - If req_i[owner] drops mid-burst: out_valid_o=0, lock is held, no beat occurs.
- Latency:
  - One bubble cycle between request and grant.
  - One IDLE cycle between bursts, so back-to-back bursts run at most 1 burst per (len+1) cycles.
- Fairness:
  - The pointer advances only after a completed burst.
  - The requester just served becomes lowest priority.
  - Any continuously requesting input is granted within N-1 bursts.
- Single-beat burst: last=1 on the first beat, returns to IDLE next cycle.
- Stall: out_ready_i=0 holds all state; the beat repeats until accepted.
- Reset mid-burst: immediate return to reset values; no partial-burst recovery.
- req_last_i of non-owners is don't-care.

Optional Feature:
- Macro RR_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - Counter hold_cnt (width $clog2(MAX_HOLD+1)) clears on IDLE->BUSY.
  - It increments each BUSY cycle without a beat and clears on any beat.
  - When it reaches MAX_HOLD: forced release, i.e. state <= IDLE, ptr <= owner+1.
  - Extra output timeout_o pulses 1 cycle on the forced release edge; reset 0.
- Undefined: no counter, no timeout_o port; the lock is held indefinitely.

Decomposition:
- Package rr_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e.
  - Localparam default for MAX_HOLD.
- Sub-module: the existing find_first_one cell.
  - WIDTH=N; data_i=req_i, start_i=ptr.
  - index_o feeds the owner next-state; valid_one_o gates IDLE->BUSY.
- Remaining registered logic (state, ptr, owner, optional counter) stays in rr_burst_arbiter.

Test Plan:
- Reset, N=4:
  - req_i=4'b1010 from cycle 0; one cycle later gnt_o=4'b0010, gnt_idx_o=1.
  - 3-beat burst with out_ready_i=1: done, ptr=2.
  - After one IDLE cycle, gnt_o=4'b1000.
- Fairness:
  - req_i=4'b1111 held, single-beat bursts, ready=1.
  - Grant order 0,1,2,3,0; each grant is followed by one IDLE cycle.
- Backpressure:
  - Owner 2 in BUSY, out_ready_i=0 for 5 cycles.
  - gnt_o=4'b0100 and out_valid_o=1 hold; no state change; burst ends after last beat with ready=1.
- Request gap:
  - Owner 1 drops req_i[1] for 2 cycles mid-burst while req_i[3]=1.
  - out_valid_o=0, gnt_o stays 4'b0010, requester 3 is not granted until 1's last beat.
- Wrap and async reset:
  - Owner 3 completes its burst: ptr=0.
  - Assert rst_ni low mid-burst: all outputs 0 in the same cycle, ptr=0.
- With RR_ARB_HOLD_TIMEOUT_EN, MAX_HOLD=16:
  - Owner 0 with ready=0 for 16 cycles: timeout_o pulses, state IDLE, ptr=1.
  - Next grant goes to the next requester in order.
